acc_c_muldiv_responder: RTL

ACC_C_MULDIV_RESPONDER -- requirements
Module: acc_c_muldiv_responder

---
 rtl/acc_c_muldiv_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/acc_c_muldiv_responder.sv
// Offloaded-instruction responder for a custom-0 opcode: serial shift-add
// MUL/MULHU (one step per cycle) and single-cycle CPOP, one request in flight.
module acc_c_muldiv_responder #(
    parameter int unsigned DataWidth = 32,
    parameter logic [6:0]  OpCode    = 7'b0001011
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 q_valid_i,
    output logic                 q_ready_o,
    input  logic [31:0]          q_instr_data_i,
    input  logic [DataWidth-1:0] q_rs1_i,
    input  logic [DataWidth-1:0] q_rs2_i,
    input  logic [DataWidth-1:0] q_hart_id_i,
    output logic                 p_valid_o,
    input  logic                 p_ready_i,
    output logic [DataWidth-1:0] p_data_o,
    output logic [4:0]           p_rd_o,
    output logic [DataWidth-1:0] p_hart_id_o,
    output logic                 p_error_o
);

    localparam int unsigned CntW = $clog2(DataWidth) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
    typedef enum logic [1:0] {OP_MUL, OP_MULHU, OP_CPOP, OP_ILL} op_e;

    state_e                   state_q, state_d;
    op_e                      op_q, op_d, dec_op;
    logic [DataWidth-1:0]     rs1_q, rs1_d;
    logic [2*DataWidth-1:0]   acc_q, acc_d, acc_step;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic                     q_ready_q, q_ready_d;
    logic                     p_valid_q, p_valid_d;
    logic [DataWidth-1:0]     p_data_q, p_data_d;
    logic [4:0]               p_rd_q, p_rd_d;
    logic [DataWidth-1:0]     p_hart_q, p_hart_d;
    logic                     p_error_q, p_error_d;
    logic [DataWidth-1:0]     popcnt;
    logic [DataWidth-1:0]     addend;
    logic [DataWidth:0]       add_sum;
    logic                     unused_instr_bits;

    // Register-index fields of the instruction are not needed by this unit.
    assign unused_instr_bits = ^q_instr_data_i[24:15];

    // Decode the incoming instruction word into an operation.
    always_comb begin
        dec_op = OP_ILL;
        if (q_instr_data_i[6:0] == OpCode && q_instr_data_i[31:25] == 7'b0) begin
            case (q_instr_data_i[14:12])
                3'b000:  dec_op = OP_MUL;
                3'b001:  dec_op = OP_MULHU;
                3'b010:  dec_op = OP_CPOP;
                default: dec_op = OP_ILL;
            endcase
        end
    end

    // Population count of the incoming rs1 operand.
    always_comb begin
        popcnt = '0;
        for (int unsigned i = 0; i < DataWidth; i++) begin
            popcnt = popcnt + {{(DataWidth-1){1'b0}}, q_rs1_i[i]};
        end
    end

    // One shift-add step: upper half accumulates rs1 when the multiplier LSB is set.
    always_comb begin
        addend   = acc_q[0] ? rs1_q : '0;
        add_sum  = {1'b0, acc_q[2*DataWidth-1:DataWidth]} + {1'b0, addend};
        acc_step = {add_sum, acc_q[DataWidth-1:1]};
    end

    // Next-state and next-output computation for the responder FSM.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        p_data_d  = p_data_q;
        p_rd_d    = p_rd_q;
        p_hart_d  = p_hart_q;
        p_error_d = p_error_q;

        case (state_q)
            IDLE: begin
                if (q_valid_i && q_ready_q) begin
                    op_d     = dec_op;
                    rs1_d    = q_rs1_i;
                    p_rd_d   = q_instr_data_i[11:7];
                    p_hart_d = q_hart_id_i;
                    case (dec_op)
                        OP_MUL, OP_MULHU: begin
                            acc_d     = {{DataWidth{1'b0}}, q_rs2_i};
                            cnt_d     = '0;
                            p_error_d = 1'b0;
                            state_d   = BUSY;
                        end
                        OP_CPOP: begin
                            p_data_d  = popcnt;
                            p_error_d = 1'b0;
                            state_d   = RESP;
                        end
                        default: begin
                            p_data_d  = '0;
                            p_error_d = 1'b1;
                            state_d   = RESP;
                        end
                    endcase
                end
            end
            BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(DataWidth - 1)) begin
                    state_d  = RESP;
                    p_data_d = (op_q == OP_MULHU) ? acc_step[2*DataWidth-1:DataWidth]
                                                  : acc_step[DataWidth-1:0];
                end
            end
            RESP: begin
                if (p_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered so they are low throughout reset.
        q_ready_d = (state_d == IDLE);
        p_valid_d = (state_d == RESP);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            rs1_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            q_ready_q <= 1'b0;
            p_valid_q <= 1'b0;
            p_data_q  <= '0;
            p_rd_q    <= '0;
            p_hart_q  <= '0;
            p_error_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            q_ready_q <= q_ready_d;
            p_valid_q <= p_valid_d;
            p_data_q  <= p_data_d;
            p_rd_q    <= p_rd_d;
            p_hart_q  <= p_hart_d;
            p_error_q <= p_error_d;
        end
    end

    assign q_ready_o   = q_ready_q;
    assign p_valid_o   = p_valid_q;
    assign p_data_o    = p_data_q;
    assign p_rd_o      = p_rd_q;
    assign p_hart_id_o = p_hart_q;
    assign p_error_o   = p_error_q;

endmodule
